wb_select_stage: RTL and testbench

Parametrised, registered write-back selector for the pipelined CPU core. Each cycle it accepts at most one retiring instruction and picks its destination register and write data from four sources: ALU result, load data, link address or upper immediate. Load data is lane-extracted and sign/zero-extended here. It drives the register-file write port, which also serves as the forwarding source, and keeps a retired-instruction counter.

---
 rtl/wb_select_stage.sv | 93 +++++++++
 tb/tb_wb_select_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
// Write-back select stage: picks destination index and data from ALU, load, link or immediate,
// registers the register-file write port and counts retired instructions.
module wb_select_stage #(
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 5,
    parameter int LINK_IDX    = 31,
    parameter int LINK_OFFSET = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        sel,
    input  logic [IDX_W-1:0]  nd,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [1:0]        mem_off,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    input  logic              link_force,
    output logic              reg_we,
    output logic [IDX_W-1:0]  reg_index,
    output logic [DATA_W-1:0] reg_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    logic              acc;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic              ext;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] sel_data;
    logic [IDX_W-1:0]  sel_idx;

    assign in_ready = ~stall;
    assign acc      = in_valid & ~stall & ~flush;

    // Halfword lanes are always 16-bit aligned, so offset bit 0 is dropped.
    assign byte_lane = mem_data[{mem_off, 3'b000} +: 8];
    assign half_lane = mem_data[{mem_off[1], 4'b0000} +: 16];

    always_comb begin
        ext      = 1'b0;
        load_val = mem_data;
        case (mem_size)
            2'b00: begin
                ext      = ~mem_unsigned & byte_lane[7];
                load_val = {{(DATA_W-8){ext}}, byte_lane};
            end
            2'b01: begin
                ext      = ~mem_unsigned & half_lane[15];
                load_val = {{(DATA_W-16){ext}}, half_lane};
            end
            default: load_val = mem_data;
        endcase

        case (sel)
            SEL_ALU:  sel_data = alu_res;
            SEL_MEM:  sel_data = load_val;
            SEL_LINK: sel_data = pc + DATA_W'(LINK_OFFSET);
            default:  sel_data = imm;
        endcase

        sel_idx = (sel == SEL_LINK && link_force) ? IDX_W'(LINK_IDX) : nd;
    end

    // Index 0 still updates index/data and the counter; only the write strobe is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we     <= 1'b0;
            reg_index  <= '0;
            reg_data   <= '0;
            retire_cnt <= '0;
        end else begin
            reg_we <= acc && (sel_idx != '0);
            if (acc) begin
                reg_index  <= sel_idx;
                reg_data   <= sel_data;
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Randomised and directed bench for wb_select_stage with a queue-based scoreboard.
module tb_wb_select_stage;

    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        in_ready;
    logic [1:0]  sel = 2'b00;
    logic [4:0]  nd = '0;
    logic [31:0] alu_res = '0, mem_data = '0, imm = '0, pc = '0;
    logic [1:0]  mem_size = 2'b00, mem_off = 2'b00;
    logic        mem_unsigned = 1'b0, link_force = 1'b0;
    logic        reg_we;
    logic [4:0]  reg_index;
    logic [31:0] reg_data;
    logic [CW-1:0] retire_cnt;

    wb_select_stage #(.DATA_W(32), .IDX_W(5), .LINK_IDX(31), .LINK_OFFSET(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
        .flush(flush), .sel(sel), .nd(nd), .alu_res(alu_res), .mem_data(mem_data),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_off(mem_off), .imm(imm),
        .pc(pc), .link_force(link_force), .reg_we(reg_we), .reg_index(reg_index),
        .reg_data(reg_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference state: what the write port should show after each edge.
    logic        m_we = 1'b0;
    logic [4:0]  m_idx = '0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_data();
        longint v;
        int     sh;
        case (sel)
            2'd0: return alu_res;
            2'd2: return pc + 32'd4;
            2'd3: return imm;
            default: begin
                if (mem_size >= 2) return mem_data;
                sh = (mem_size == 0) ? int'(mem_off) : (int'(mem_off) & 2);
                v  = longint'(mem_data >> (8 * sh));
                if (mem_size == 0) begin
                    v = v % 256;
                    if (!mem_unsigned && v >= 128) v = v - 256;
                end else begin
                    v = v % 65536;
                    if (!mem_unsigned && v >= 32768) v = v - 65536;
                end
                return v[31:0];
            end
        endcase
    endfunction

    // Applies the current inputs for one cycle, queues the expected post-edge state.
    task automatic cycle();
        logic [4:0] idx;
        bit acc;
        exp_t e;
        #1;
        check("in_ready", in_ready, !stall);
        if (rst) begin
            m_we = 0; m_idx = 0; m_data = 0; m_cnt = 0;
        end else begin
            acc = in_valid && !stall && !flush;
            idx = (sel == 2'd2 && link_force) ? 5'd31 : nd;
            m_we = acc && (idx != 0);
            if (acc) begin
                m_idx  = idx;
                m_data = model_data();
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
        end
        e.we = m_we; e.idx = m_idx; e.data = m_data; e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("reg_we", reg_we, e.we);
            check("reg_index", reg_index, e.idx);
            check("reg_data", reg_data, e.data);
            check("retire_cnt", retire_cnt, e.cnt);
        end
    end

    task automatic alu_op(input logic [4:0] d, input logic [31:0] a);
        in_valid = 1; sel = 2'd0; nd = d; alu_res = a;
        cycle();
    endtask

    task automatic link_op(input logic [31:0] p, input logic lf, input logic [4:0] d);
        in_valid = 1; sel = 2'd2; pc = p; link_force = lf; nd = d;
        cycle();
    endtask

    task automatic load_op(input logic [1:0] sz, input logic [1:0] off, input logic uns);
        in_valid = 1; sel = 2'd1; nd = 5'd9; mem_data = 32'h80FF7F01;
        mem_size = sz; mem_off = off; mem_unsigned = uns;
        cycle();
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0;
        cycle();
    endtask

    initial begin
        @(negedge clk); #1;
        cycle(); cycle();
        rst = 0;

        alu_op(5'd5, 32'h1234);
        link_op(32'h00400010, 1, 5'd7);
        link_op(32'h00400010, 0, 5'd7);
        link_op(32'hFFFFFFFC, 0, 5'd7);
        load_op(2'b00, 2'd3, 0);
        load_op(2'b00, 2'd3, 1);
        load_op(2'b01, 2'd2, 0);
        load_op(2'b01, 2'd3, 1);
        load_op(2'b00, 2'd1, 0);
        load_op(2'b10, 2'd3, 0);
        idle();

        // Held by stall for three cycles, accepted once released.
        in_valid = 1; sel = 2'd3; nd = 5'd12; imm = 32'hABCD0000;
        stall = 1; cycle(); cycle(); cycle();
        stall = 0; cycle();
        idle();

        alu_op(5'd3, 32'h11111111);
        flush = 1; alu_op(5'd4, 32'h22222222);
        stall = 1; alu_op(5'd6, 32'h33333333);
        in_valid = 0; cycle();
        idle();

        alu_op(5'd0, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) alu_op(5'(10 + i), 32'h100 * (i + 1));
        idle();

        // Reset asserted mid-cycle with a valid op on the inputs.
        in_valid = 1; sel = 2'd0; nd = 5'd8; alu_res = 32'h5555AAAA;
        rst = 1; #1;
        check("rst_we", reg_we, 0);
        check("rst_index", reg_index, 0);
        check("rst_data", reg_data, 0);
        check("rst_cnt", retire_cnt, 0);
        cycle();
        rst = 0;
        alu_op(5'd5, 32'h1234);
        for (int i = 0; i < 7; i++) alu_op(5'd1, 32'(i));
        idle();

        for (int i = 0; i < 300; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 6) == 0);
            sel          = 2'($urandom);
            nd           = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu_res      = $urandom;
            mem_data     = $urandom;
            mem_size     = 2'($urandom);
            mem_off      = 2'($urandom);
            mem_unsigned = 1'($urandom);
            imm          = $urandom;
            pc           = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
            link_force   = 1'($urandom);
            cycle();
        end
        idle();

        @(negedge clk); @(negedge clk); #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
